muldiv_controller: RTL and testbench

Iterative multiply/divide sequencer for the five-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU issued from the execute stage and runs a 32-iteration shift-add or restoring-divide sequence. Owns the HI/LO registers. Raises a stall request that the hazard controller merges into its fetch/decode freeze while a result is pending.

---
 rtl/muldiv_controller_pkg.sv | 25 ++
 rtl/muldiv_controller_step.sv | 34 +++
 rtl/muldiv_controller.sv | 121 ++++++++++++
 tb/tb_muldiv_controller.sv | 135 +++++++++++++
 4 files changed

// File: rtl/muldiv_controller_pkg.sv
// Shared multiply/divide operation and sequencer state encodings.
package global_types;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } md_state_t;

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_controller_step.sv
// One unsigned iteration: add-and-shift multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_upper,
  input  logic             i_lo_msb,
  input  logic             i_lo_lsb,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_upper,
  output logic             o_bit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  always_comb begin
    w_sum   = {1'b0, i_upper} + (i_lo_lsb ? {1'b0, i_operand} : '0);
    w_shift = {i_upper, i_lo_msb};
    w_diff  = w_shift - {1'b0, i_operand};
    w_ge    = ~w_diff[WIDTH];
    if (i_div) begin
      o_upper = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      o_bit   = w_ge;
    end else begin
      // o_bit is the sum LSB that shifts into the top of the low half
      o_upper = w_sum[WIDTH:1];
      o_bit   = w_sum[0];
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls the front end while busy.
import global_types::*;

module muldiv_controller #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_start,
  input  logic [1:0]       e_op,
  input  logic [WIDTH-1:0] e_rs_val,
  input  logic [WIDTH-1:0] e_rt_val,
  input  logic             e_read_hilo,
  output logic             md_stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t          r_state;
  md_op_t             r_op;
  logic               r_sign_a, r_sign_b, r_div0, r_done;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;

  md_op_t             w_op;
  logic               w_div_in, w_sa, w_sb, w_is_div, w_is_signed, w_bit;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_upper, w_fix_hi, w_fix_lo;

  always_comb begin
    w_op        = md_op_t'(e_op);
    w_div_in    = md_is_div(w_op);
    w_sa        = md_is_signed(w_op) & e_rs_val[WIDTH-1];
    w_sb        = md_is_signed(w_op) & e_rt_val[WIDTH-1];
    w_mag_a     = w_sa ? (~e_rs_val + 1'b1) : e_rs_val;
    w_mag_b     = w_sb ? (~e_rt_val + 1'b1) : e_rt_val;
    w_is_div    = md_is_div(r_op);
    w_is_signed = md_is_signed(r_op);
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div     (w_is_div),
    .i_upper   (r_acc[2*WIDTH-1:WIDTH]),
    .i_lo_msb  (r_acc[WIDTH-1]),
    .i_lo_lsb  (r_acc[0]),
    .i_operand (r_opnd),
    .o_upper   (w_upper),
    .o_bit     (w_bit)
  );

  // Divide-by-zero keeps the raw all-ones quotient and latched dividend.
  always_comb begin
    w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
    w_fix_lo = r_acc[WIDTH-1:0];
    if (!w_is_div) begin
      if (w_is_signed && (r_sign_a ^ r_sign_b))
        {w_fix_hi, w_fix_lo} = ~r_acc + 1'b1;
    end else if (w_is_signed && !r_div0) begin
      if (r_sign_a ^ r_sign_b) w_fix_lo = ~r_acc[WIDTH-1:0] + 1'b1;
      if (r_sign_a)            w_fix_hi = ~r_acc[2*WIDTH-1:WIDTH] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_op     <= MD_MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (e_start) begin
            r_op     <= w_op;
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_div0   <= (e_rt_val == '0);
            r_opnd   <= w_div_in ? w_mag_b : w_mag_a;
            r_acc    <= {{WIDTH{1'b0}}, (w_div_in ? w_mag_a : w_mag_b)};
            r_cnt    <= CW'(WIDTH - 1);
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (w_is_div)
            r_acc <= {w_upper, r_acc[WIDTH-2:0], w_bit};
          else
            r_acc <= {w_upper, w_bit, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_state <= FIXUP;
        end
        FIXUP: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign md_stall = busy & (e_read_hilo | e_start);
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed checks of muldiv_controller results, timing, stall and reset behaviour.
import global_types::*;

module tb_muldiv_controller;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, e_start, e_read_hilo;
  logic [1:0]   e_op;
  logic [W-1:0] e_rs_val, e_rt_val;
  logic         md_stall, busy, done;
  logic [W-1:0] hi, lo;

  int unsigned  total = 0;
  int unsigned  bad = 0;
  int unsigned  stall_cnt;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  muldiv_controller #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .e_start     (e_start),
    .e_op        (e_op),
    .e_rs_val    (e_rs_val),
    .e_rt_val    (e_rt_val),
    .e_read_hilo (e_read_hilo),
    .md_stall    (md_stall),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start at edge 0, expect result exactly at edge W+1 and a single done pulse.
  task automatic run_op(input string tag, input md_op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] nh, input logic [W-1:0] nl);
    @(negedge clk);
    e_start = 1'b1; e_op = op; e_rs_val = a; e_rt_val = b;
    @(posedge clk); #1;
    e_start = 1'b0; e_rs_val = '0; e_rt_val = '0;
    chk({tag, ".busy0"}, busy, 1);
    repeat (W) @(posedge clk);
    #1;
    chk({tag, ".busy32"}, busy, 1);
    chk({tag, ".hold32"}, {hi, lo}, {exp_hi, exp_lo});
    chk({tag, ".done32"}, done, 0);
    @(posedge clk); #1;
    chk({tag, ".busy33"}, busy, 0);
    chk({tag, ".done33"}, done, 1);
    chk({tag, ".hilo"}, {hi, lo}, {nh, nl});
    exp_hi = nh; exp_lo = nl;
    @(posedge clk); #1;
    chk({tag, ".done34"}, done, 0);
  endtask

  initial begin
    reset = 1'b0; e_start = 1'b1; e_read_hilo = 1'b1; e_op = 2'd0;
    e_rs_val = '0; e_rt_val = '0;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.stall", md_stall, 0);
    chk("rst.hilo", {hi, lo}, 64'h0);
    e_start = 1'b0; e_read_hilo = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    run_op("mult",   MD_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div",    MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divmin", MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div0s",  MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
    run_op("divu0",  MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);

    // MFHI/MFLO stalled behind a MULTU; a second start while busy must be ignored.
    @(negedge clk);
    e_start = 1'b1; e_op = MD_MULTU; e_rs_val = 32'd5; e_rt_val = 32'd6;
    @(posedge clk); #1;
    e_start = 1'b0; e_read_hilo = 1'b1;
    stall_cnt = 0;
    for (int e = 0; e <= 32; e++) begin
      if (md_stall) stall_cnt++;
      if (e == 5) begin
        e_start = 1'b1; e_op = MD_MULTU; e_rs_val = 32'd9; e_rt_val = 32'd9;
      end
      if (e == 20) e_start = 1'b0;
      if (e == 32) chk("stall.hold", {hi, lo}, {exp_hi, exp_lo});
      @(posedge clk); #1;
    end
    chk("stall.count", stall_cnt, 33);
    chk("stall.release", md_stall, 0);
    chk("stall.busy", busy, 0);
    chk("stall.done", done, 1);
    chk("stall.hilo", {hi, lo}, {32'h0, 32'h0000001E});
    exp_hi = '0; exp_lo = 32'h1E;
    e_read_hilo = 1'b0;
    @(posedge clk); #1;
    chk("stall.noqueue", busy, 0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    e_start = 1'b1; e_op = MD_MULTU; e_rs_val = 32'd12345; e_rt_val = 32'd678;
    @(posedge clk); #1;
    e_start = 1'b0; e_read_hilo = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("arst.pre_stall", md_stall, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.stall", md_stall, 0);
    chk("arst.hilo", {hi, lo}, 64'h0);
    exp_hi = '0; exp_lo = '0;
    e_read_hilo = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
